// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
//
// Carries the decoder's per-instruction control bundle through the EX, MEM and
// WB stage registers. Inserts bubbles on load-use stalls and branch flushes,
// runs the EBREAK halt/drain state machine and drives the PC and IF/ID enables.
//
// Parameters
//   CW     control bundle width (only 15 is supported)
//   CNT_W  retired-instruction counter width (optional counter only)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   id_valid    in   decode stage holds a real instruction
//   id_ctrl     in   control bundle from decode
//                    [0]Branch [1]MemRead [2]MemtoReg [3]MemWrite [4]ALUSrc
//                    [5]RegWrite [6]PCLoad [7]Jump [10:8]ALUOp
//                    [12:11]RegWriteSrc [14:13]PCSrc
//   stall       in   load-use hazard: hold PC and IF/ID, bubble into EX
//   flush       in   taken branch/jump resolved in MEM: kill EX and ID
//   resume      in   single-cycle pulse that leaves HALTED
//   ex_valid    out  EX stage occupied
//   ex_ctrl     out  EX stage bundle
//   mem_valid   out  MEM stage occupied
//   mem_ctrl    out  MEM stage bundle
//   wb_valid    out  WB stage occupied
//   wb_ctrl     out  WB stage bundle
//   pc_en       out  PC register load enable
//   ifid_en     out  IF/ID register load enable
//   ifid_flush  out  clear IF/ID this cycle
//   halted      out  core halted on EBREAK
//   retire_cnt  out  retired-instruction count (only with the macro below)
//
// Optional feature
//   CTRL_PIPE_RETIRE_CNT_EN  when defined, adds the retire_cnt port and a
//                            counter that increments on every edge where the
//                            WB stage is occupied, wrapping modulo 2^CNT_W.
// -----------------------------------------------------------------------------
module ctrl_pipe #(
    parameter int CW    = 15,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [CW-1:0] id_ctrl,
    input  logic          stall,
    input  logic          flush,
    input  logic          resume,
    output logic          ex_valid,
    output logic [CW-1:0] ex_ctrl,
    output logic          mem_valid,
    output logic [CW-1:0] mem_ctrl,
    output logic          wb_valid,
    output logic [CW-1:0] wb_ctrl,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          ifid_flush,
    output logic          halted
`ifdef CTRL_PIPE_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    localparam int PCLOAD_BIT = 6;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Stage registers; the ebreak tag travels with the instruction so the FSM
    // knows when the halting instruction has reached WB or was killed in EX.
    logic          r_ex_valid;
    logic [CW-1:0] r_ex_ctrl;
    logic          r_ex_ebreak;
    logic          r_mem_valid;
    logic [CW-1:0] r_mem_ctrl;
    logic          r_mem_ebreak;
    logic          r_wb_valid;
    logic [CW-1:0] r_wb_ctrl;
    logic          r_wb_ebreak;

    logic          w_accept;
    logic          w_accept_ebreak;

    // Decode is only sampled in RUN and only when neither hazard is active;
    // in DRAIN/HALTED the ID stage is treated as a bubble.
    assign w_accept        = (r_state == S_RUN) & ~flush & ~stall & id_valid;
    assign w_accept_ebreak = w_accept & ~id_ctrl[PCLOAD_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_ebreak  <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_ctrl   <= '0;
            r_mem_ebreak <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_ctrl    <= '0;
            r_wb_ebreak  <= 1'b0;
        end else begin
            r_ex_valid  <= w_accept;
            r_ex_ctrl   <= w_accept ? id_ctrl : '0;
            r_ex_ebreak <= w_accept_ebreak;

            // A flush kills the instruction sitting in EX, so MEM gets a
            // bubble instead of it; the older MEM instruction still retires.
            if (flush) begin
                r_mem_valid  <= 1'b0;
                r_mem_ctrl   <= '0;
                r_mem_ebreak <= 1'b0;
            end else begin
                r_mem_valid  <= r_ex_valid;
                r_mem_ctrl   <= r_ex_ctrl;
                r_mem_ebreak <= r_ex_ebreak;
            end

            r_wb_valid  <= r_mem_valid;
            r_wb_ctrl   <= r_mem_ctrl;
            r_wb_ebreak <= r_mem_ebreak;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_RUN: begin
                ifid_en = ~stall;
                // The branch target must be loaded even while a load-use
                // stall is pending.
                pc_en   = ~stall | flush;
                if (w_accept_ebreak) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // EBREAK on the wrong path of a taken branch: abandon halt.
                if (flush && r_ex_ebreak) begin
                    w_state_next = S_RUN;
                end else if (r_wb_ebreak) begin
                    w_state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    assign ifid_flush = flush;

    assign ex_valid  = r_ex_valid;
    assign ex_ctrl   = r_ex_ctrl;
    assign mem_valid = r_mem_valid;
    assign mem_ctrl  = r_mem_ctrl;
    assign wb_valid  = r_wb_valid;
    assign wb_ctrl   = r_wb_ctrl;

`ifdef CTRL_PIPE_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (r_wb_valid) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    // Counter width only matters when the counter is built.
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule
